epb_pes_sched: RTL

EPB_PES_SCHED -- requirements
Module: epb_pes_sched

---
 rtl/epb_pes_sched.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/epb_pes_sched.sv
// epb_pes_sched: deficit-round-robin scheduler that picks packets from the
// EPB traffic-class queues and offers them to the PES, gated by PES buffer
// credits.
//
// Ports
//   cclk, rst          : clock, synchronous active-high reset
//   cfg_quantum        : per-TC DRR quantum in bytes, TC i at [i*DEF_W +: DEF_W]
//   epb_q_nonempty     : bit i set when TC i holds at least one packet
//   epb_q_head_len     : head packet length per TC, TC i at [i*LEN_W +: LEN_W]
//   epb_deq            : one-hot pop pulse for the accepted TC head
//   sched_valid/ready  : offer handshake towards the PES
//   sched_tc/len       : TC and length of the offered packet
//   pes_credit_ret     : one-cycle pulse returning one PES credit
//   credit_cnt         : current credit count
//   cred_ovf_err       : sticky flag, credit returned while already full
//   dbg_state          : FSM state (0 = SCAN, 1 = OFFER)
//
// Handshake: an offer is transferred in the cycle where sched_valid and
// sched_ready are both high. Once sched_valid rises, sched_tc and sched_len
// stay constant until that transfer cycle; sched_valid never drops without a
// transfer except on reset. sched_valid is low in the cycle after a transfer.
module epb_pes_sched #(
    parameter int N_TC     = 8,
    parameter int LEN_W    = 14,
    parameter int DEF_W    = 16,
    parameter int MAX_CRED = 32,
    localparam int TC_W    = (N_TC > 1) ? $clog2(N_TC) : 1,
    localparam int CNT_W   = $clog2(MAX_CRED + 1)
) (
    input  logic                    cclk,
    input  logic                    rst,
    input  logic [N_TC*DEF_W-1:0]   cfg_quantum,
    input  logic [N_TC-1:0]         epb_q_nonempty,
    input  logic [N_TC*LEN_W-1:0]   epb_q_head_len,
    output logic [N_TC-1:0]         epb_deq,
    output logic                    sched_valid,
    output logic [TC_W-1:0]         sched_tc,
    output logic [LEN_W-1:0]        sched_len,
    input  logic                    sched_ready,
    input  logic                    pes_credit_ret,
    output logic [CNT_W-1:0]        credit_cnt,
    output logic                    cred_ovf_err,
    output logic                    dbg_state
);

    // Common width for comparing/subtracting a deficit against a length.
    localparam int CW = (DEF_W > LEN_W) ? DEF_W : LEN_W;

    typedef enum logic {SCAN = 1'b0, OFFER = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [TC_W-1:0]    ptr_q, ptr_d;
    logic [TC_W-1:0]    tc_q, tc_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [DEF_W-1:0]   def_q [N_TC];
    logic [DEF_W-1:0]   def_d [N_TC];
    logic [CNT_W-1:0]   cred_q, cred_d;
    logic               ovf_q, ovf_d;

    logic [DEF_W-1:0]   quant [N_TC];
    logic [LEN_W-1:0]   hlen  [N_TC];

    always_comb begin
        for (int i = 0; i < N_TC; i++) begin
            quant[i] = cfg_quantum[i*DEF_W +: DEF_W];
            hlen[i]  = epb_q_head_len[i*LEN_W +: LEN_W];
        end
    end

    // Candidate TC under the scan pointer.
    logic               cur_ne;
    logic [DEF_W-1:0]   cur_quant;
    logic [LEN_W-1:0]   cur_len;
    logic [DEF_W-1:0]   cur_def;
    logic [DEF_W:0]     sum_ext;
    logic [DEF_W-1:0]   sat_sum;
    logic [TC_W-1:0]    ptr_nxt;
    logic [DEF_W-1:0]   def_after;
    logic               accept;

    assign cur_ne    = epb_q_nonempty[ptr_q];
    assign cur_quant = quant[ptr_q];
    assign cur_len   = hlen[ptr_q];
    assign cur_def   = def_q[ptr_q];
    assign sum_ext   = {1'b0, cur_def} + {1'b0, cur_quant};
    assign sat_sum   = sum_ext[DEF_W] ? '1 : sum_ext[DEF_W-1:0];
    assign ptr_nxt   = (ptr_q == TC_W'(N_TC - 1)) ? '0 : ptr_q + 1'b1;
    // The offer was only made when def >= len, so this cannot underflow.
    assign def_after = DEF_W'(CW'(def_q[tc_q]) - CW'(len_q));
    assign accept    = (state_q == OFFER) && sched_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        tc_d    = tc_q;
        len_d   = len_q;
        def_d   = def_q;
        case (state_q)
            SCAN: begin
                // No credit: the whole scheduler freezes, pointer included.
                if (cred_q != '0) begin
                    if (!cur_ne || (cur_quant == '0)) begin
                        def_d[ptr_q] = '0;
                        ptr_d        = ptr_nxt;
                    end else if (CW'(cur_def) < CW'(cur_len)) begin
                        def_d[ptr_q] = sat_sum;
                        ptr_d        = ptr_nxt;
                    end else begin
                        tc_d    = ptr_q;
                        len_d   = cur_len;
                        state_d = OFFER;
                    end
                end
            end
            OFFER: begin
                // Pointer stays put so the same TC keeps spending its deficit.
                if (sched_ready) begin
                    def_d[tc_q] = def_after;
                    state_d     = SCAN;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        cred_d = cred_q;
        ovf_d  = ovf_q;
        if (pes_credit_ret && !accept) begin
            if (cred_q == CNT_W'(MAX_CRED)) begin
                ovf_d = 1'b1;
            end else begin
                cred_d = cred_q + 1'b1;
            end
        end else if (accept && !pes_credit_ret) begin
            cred_d = cred_q - 1'b1;
        end
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q <= SCAN;
            ptr_q   <= '0;
            tc_q    <= '0;
            len_q   <= '0;
            cred_q  <= CNT_W'(MAX_CRED);
            ovf_q   <= 1'b0;
            for (int i = 0; i < N_TC; i++) begin
                def_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            tc_q    <= tc_d;
            len_q   <= len_d;
            cred_q  <= cred_d;
            ovf_q   <= ovf_d;
            def_q   <= def_d;
        end
    end

    // Outputs are forced to their reset values while rst is high, so an
    // offer pending when reset arrives is dropped without a pop.
    assign sched_valid  = (state_q == OFFER) && !rst;
    assign sched_tc     = rst ? '0 : tc_q;
    assign sched_len    = rst ? '0 : len_q;
    assign credit_cnt   = rst ? CNT_W'(MAX_CRED) : cred_q;
    assign cred_ovf_err = ovf_q && !rst;
    assign dbg_state    = (state_q == OFFER);

    always_comb begin
        epb_deq = '0;
        if (sched_valid && sched_ready) begin
            epb_deq[tc_q] = 1'b1;
        end
    end

endmodule
